// File: rtl/stepper_seq_if.sv
// Command/status bundle between the motion-control wrapper and the stepper sequencer.
// The master drives the cmd_* fields and abort, and the slave drives the status and coil outputs.
interface stepper_seq_if #(
  parameter int STEP_W = 16,
  parameter int DIV_W  = 32,
  parameter int POS_W  = 32
);
  // Handshake: a command transfers on any rising clock_clk edge where cmd_valid && cmd_ready.
  // cmd_ready is high only while the sequencer is idle.
  // The cmd_* fields are sampled only on that edge and may change freely afterwards.
  logic              cmd_valid;
  logic              cmd_ready;
  logic [STEP_W-1:0] cmd_steps;
  logic              cmd_dir;
  logic [1:0]        cmd_mode;
  logic [DIV_W-1:0]  cmd_period;
  logic              abort;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [3:0]        coil_out;
  logic [3:0]        coil_oe;
  logic [1:0]        en_out;
  logic [POS_W-1:0]  position;

  modport master (
    output cmd_valid, cmd_steps, cmd_dir, cmd_mode, cmd_period, abort,
    input  cmd_ready, busy, done, aborted, coil_out, coil_oe, en_out, position
  );

  modport slave (
    input  cmd_valid, cmd_steps, cmd_dir, cmd_mode, cmd_period, abort,
    output cmd_ready, busy, done, aborted, coil_out, coil_oe, en_out, position
  );
endinterface

// File: rtl/stepper_seq_driver.sv
// Unipolar 4-coil stepper sequencer: executes one queued move at a time with a programmable step
// period, wave/full/half drive, abort, optional hold torque and a signed position counter.
module stepper_seq_driver #(
  parameter int STEP_W     = 16,
  parameter int DIV_W      = 32,
  parameter int POS_W      = 32,
  parameter int HOLD       = 1,
  parameter int MIN_PERIOD = 2
) (
  input  logic         clock_clk,
  input  logic         reset_low,
  stepper_seq_if.slave bus,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        phase_q, phase_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic [STEP_W-1:0] remain_q, remain_d;
  logic [DIV_W-1:0]  timer_q, timer_d;
  logic [DIV_W-1:0]  period_q, period_d;
  logic              half_q, half_d;
  logic              dir_q, dir_d;
  logic              aborted_q, aborted_d;
  logic              moved_q, moved_d;

  logic [DIV_W-1:0]  min_per;
  logic [2:0]        step_amt;
  logic              energise;
  logic [1:0]        coil_a;

  assign min_per  = DIV_W'(MIN_PERIOD);
  assign step_amt = half_q ? 3'd1 : 3'd2;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    pos_d     = pos_q;
    remain_d  = remain_q;
    timer_d   = timer_q;
    period_d  = period_q;
    half_d    = half_q;
    dir_d     = dir_q;
    aborted_d = aborted_q;
    moved_d   = moved_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          aborted_d = 1'b0;
          if (bus.cmd_steps == '0) begin
            state_d = S_DONE;
          end else begin
            state_d  = S_RUN;
            moved_d  = 1'b1;
            remain_d = bus.cmd_steps;
            dir_d    = bus.cmd_dir;
            half_d   = bus.cmd_mode[1];
            timer_d  = DIV_W'(1);
            period_d = (bus.cmd_period < min_per) ? min_per : bus.cmd_period;
            // Wave sits on even phases, full on odd ones; half keeps wherever the rotor is.
            if (bus.cmd_mode == 2'd0)      phase_d = {phase_q[2:1], 1'b0};
            else if (bus.cmd_mode == 2'd1) phase_d = {phase_q[2:1], 1'b1};
          end
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          state_d   = S_DONE;
          aborted_d = 1'b1;
        end else if (timer_q >= period_q) begin
          timer_d  = DIV_W'(1);
          phase_d  = dir_q ? phase_q + step_amt : phase_q - step_amt;
          pos_d    = dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
          remain_d = remain_q - STEP_W'(1);
          if (remain_q == STEP_W'(1)) state_d = S_DONE;
        end else begin
          timer_d = timer_q + DIV_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_clk or negedge reset_low) begin
    if (!reset_low) begin
      state_q   <= S_IDLE;
      phase_q   <= 3'd0;
      pos_q     <= '0;
      remain_q  <= '0;
      timer_q   <= '0;
      period_q  <= '0;
      half_q    <= 1'b0;
      dir_q     <= 1'b0;
      aborted_q <= 1'b0;
      moved_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      pos_q     <= pos_d;
      remain_q  <= remain_d;
      timer_q   <= timer_d;
      period_q  <= period_d;
      half_q    <= half_d;
      dir_q     <= dir_d;
      aborted_q <= aborted_d;
      moved_q   <= moved_d;
    end
  end

  // Outside RUN the last phase stays energised only with hold torque and after a real move.
  assign energise = (state_q == S_RUN) || ((HOLD != 0) && moved_q);
  assign coil_a   = phase_q[2:1];

  always_comb begin
    bus.coil_oe = 4'b0000;
    if (energise) begin
      bus.coil_oe = 4'b0001 << coil_a;
      if (phase_q[0]) bus.coil_oe = bus.coil_oe | (4'b0001 << (coil_a + 2'd1));
    end
  end

  assign bus.coil_out  = 4'b0000;
  assign bus.en_out    = energise ? 2'b11 : 2'b00;
  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.aborted   = (state_q == S_DONE) && aborted_q;
  assign bus.position  = pos_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_stepper_seq_driver.sv
// Bench for stepper_seq_driver: a HOLD=1 and a HOLD=0 instance share stimulus; a per-cycle
// expected trace is queued at each command and popped against both instances.
module tb_stepper_seq_driver;
  localparam int STEP_W     = 16;
  localparam int DIV_W      = 32;
  localparam int POS_W      = 32;
  localparam int MIN_PERIOD = 2;
  localparam int W          = 46;

  logic clock_clk = 1'b0;
  logic reset_low = 1'b0;
  logic [1:0] dbg1, dbg0;
  always #5 clock_clk = ~clock_clk;

  stepper_seq_if #(.STEP_W(STEP_W), .DIV_W(DIV_W), .POS_W(POS_W)) h1 ();
  stepper_seq_if #(.STEP_W(STEP_W), .DIV_W(DIV_W), .POS_W(POS_W)) h0 ();

  assign h0.cmd_valid  = h1.cmd_valid;
  assign h0.cmd_steps  = h1.cmd_steps;
  assign h0.cmd_dir    = h1.cmd_dir;
  assign h0.cmd_mode   = h1.cmd_mode;
  assign h0.cmd_period = h1.cmd_period;
  assign h0.abort      = h1.abort;

  stepper_seq_driver #(.STEP_W(STEP_W), .DIV_W(DIV_W), .POS_W(POS_W), .HOLD(1), .MIN_PERIOD(MIN_PERIOD))
    u_hold (.clock_clk(clock_clk), .reset_low(reset_low), .bus(h1.slave), .dbg_state(dbg1));
  stepper_seq_driver #(.STEP_W(STEP_W), .DIV_W(DIV_W), .POS_W(POS_W), .HOLD(0), .MIN_PERIOD(MIN_PERIOD))
    u_nohold (.clock_clk(clock_clk), .reset_low(reset_low), .bus(h0.slave), .dbg_state(dbg0));

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp1_q[$];
  logic [W-1:0] exp0_q[$];
  bit mon_en = 1'b0;

  int          m_p;
  logic [31:0] m_pos;
  bit          m_moved;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] phase_oe(input int p);
    case (p)
      0: return 4'b0001;  1: return 4'b0011;
      2: return 4'b0010;  3: return 4'b0110;
      4: return 4'b0100;  5: return 4'b1100;
      6: return 4'b1000;  default: return 4'b1001;
    endcase
  endfunction

  function automatic logic [W-1:0] pack(input bit dn, input bit ab, input bit bz, input bit rdy,
                                        input logic [3:0] oe, input logic [31:0] pos);
    return {dn, ab, bz, rdy, (oe != 4'b0000) ? 2'b11 : 2'b00, oe, 4'b0000, pos};
  endfunction

  function automatic int wrap8(input int v);
    return ((v % 8) + 8) % 8;
  endfunction

  // Build the expected cycle-by-cycle trace starting the cycle after the accept edge.
  task automatic push_trace(input int steps, input bit dir, input int mode, input int period,
                            input int abort_at);
    int per, inc, endj, nst, k, p0, sgn;
    bit ab;
    logic [31:0] pos0, pos;
    logic [3:0] hold1;
    per = (period < MIN_PERIOD) ? MIN_PERIOD : period;
    if (steps == 0) begin
      hold1 = m_moved ? phase_oe(m_p) : 4'b0000;
      exp1_q.push_back(pack(1, 0, 1, 0, hold1, m_pos));
      exp0_q.push_back(pack(1, 0, 1, 0, 4'b0000, m_pos));
      exp1_q.push_back(pack(0, 0, 0, 1, hold1, m_pos));
      exp0_q.push_back(pack(0, 0, 0, 1, 4'b0000, m_pos));
      return;
    end
    if (mode == 0) m_p = m_p & 6;
    else if (mode == 1) m_p = m_p | 1;
    inc  = (mode >= 2) ? 1 : 2;
    sgn  = dir ? 1 : -1;
    ab   = (abort_at > 0) && (abort_at <= steps * per);
    endj = ab ? abort_at : steps * per;
    p0   = m_p;
    pos0 = m_pos;
    for (int j = 0; j < endj; j++) begin
      k   = j / per;
      pos = dir ? pos0 + 32'(k) : pos0 - 32'(k);
      exp1_q.push_back(pack(0, 0, 1, 0, phase_oe(wrap8(p0 + sgn * k * inc)), pos));
      exp0_q.push_back(pack(0, 0, 1, 0, phase_oe(wrap8(p0 + sgn * k * inc)), pos));
    end
    nst     = ab ? (abort_at - 1) / per : steps;
    m_p     = wrap8(p0 + sgn * nst * inc);
    m_pos   = dir ? pos0 + 32'(nst) : pos0 - 32'(nst);
    m_moved = 1'b1;
    exp1_q.push_back(pack(1, ab, 1, 0, phase_oe(m_p), m_pos));
    exp0_q.push_back(pack(1, ab, 1, 0, 4'b0000, m_pos));
    exp1_q.push_back(pack(0, 0, 0, 1, phase_oe(m_p), m_pos));
    exp0_q.push_back(pack(0, 0, 0, 1, 4'b0000, m_pos));
  endtask

  task automatic run_cmd(input int steps, input bit dir, input int mode, input int period,
                         input int abort_at);
    int budget;
    @(negedge clock_clk); #1;
    push_trace(steps, dir, mode, period, abort_at);
    h1.cmd_valid  = 1'b1;
    h1.cmd_steps  = STEP_W'(steps);
    h1.cmd_dir    = dir;
    h1.cmd_mode   = 2'(mode);
    h1.cmd_period = DIV_W'(period);
    @(posedge clock_clk); #1;
    h1.cmd_valid  = 1'b0;
    h1.cmd_steps  = STEP_W'($urandom);
    h1.cmd_dir    = 1'($urandom);
    h1.cmd_mode   = 2'($urandom);
    h1.cmd_period = DIV_W'($urandom_range(0, 3));
    if (abort_at > 0) begin
      repeat (abort_at - 1) @(posedge clock_clk);
      #1 h1.abort = 1'b1;
      @(posedge clock_clk);
      #1 h1.abort = 1'b0;
    end
    budget = steps * 20 + 20;
    for (int t = 0; t < budget && exp1_q.size() > 0; t++) @(negedge clock_clk);
  endtask

  always @(negedge clock_clk) begin
    if (mon_en && exp1_q.size() > 0 && exp0_q.size() > 0) begin
      check("trace_hold", {h1.done, h1.aborted, h1.busy, h1.cmd_ready, h1.en_out, h1.coil_oe,
                           h1.coil_out, h1.position}, exp1_q.pop_front());
      check("trace_nohold", {h0.done, h0.aborted, h0.busy, h0.cmd_ready, h0.en_out, h0.coil_oe,
                             h0.coil_out, h0.position}, exp0_q.pop_front());
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_oe"},    h1.coil_oe, 4'b0000);
    check({tag, "_en"},    h1.en_out, 2'b00);
    check({tag, "_ready"}, h1.cmd_ready, 1'b1);
    check({tag, "_busy"},  h1.busy, 1'b0);
    check({tag, "_done"},  {h1.done, h1.aborted, h0.done}, 3'b000);
    check({tag, "_pos"},   h1.position, 32'd0);
    check({tag, "_state"}, dbg1, 2'd0);
  endtask

  initial begin
    int st, pr, md, ab, per;
    h1.cmd_valid = 1'b0; h1.cmd_steps = '0; h1.cmd_dir = 1'b0;
    h1.cmd_mode = 2'd0; h1.cmd_period = '0; h1.abort = 1'b0;
    m_p = 0; m_pos = 32'd0; m_moved = 1'b0;
    #12;
    check_reset_vals("reset");
    @(negedge clock_clk); reset_low = 1'b1;
    mon_en = 1'b1;

    run_cmd(4, 1, 0, 10, 0);      // wave forward from p=0
    run_cmd(3, 0, 2, 5, 0);       // half reverse 0,7,6,5
    run_cmd(2, 1, 1, 1, 0);       // full, period clamped to 2
    run_cmd(0, 1, 0, 7, 0);       // zero-length move
    run_cmd(100, 1, 0, 8, 24);    // abort on 3rd expiry
    run_cmd(3, 1, 3, 3, 0);       // mode 3 behaves as half
    run_cmd(2, 0, 0, 2, 4);       // abort on the final expiry
    for (int i = 0; i < 8; i++) begin
      st  = $urandom_range(0, 5);
      pr  = $urandom_range(0, 6);
      md  = $urandom_range(0, 3);
      per = (pr < MIN_PERIOD) ? MIN_PERIOD : pr;
      ab  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, st * per + 2) : 0;
      run_cmd(st, 1'($urandom_range(0, 1)), md, pr, ab);
    end

    // Reset in the middle of a long move.
    mon_en = 1'b0;
    @(negedge clock_clk); #1;
    h1.cmd_valid = 1'b1; h1.cmd_steps = 16'd100; h1.cmd_dir = 1'b1;
    h1.cmd_mode = 2'd2; h1.cmd_period = 32'd8;
    @(posedge clock_clk); #1 h1.cmd_valid = 1'b0;
    repeat (20) @(posedge clock_clk);
    #2 reset_low = 1'b0;
    #1 check_reset_vals("midreset");
    check("midreset_nohold_oe", h0.coil_oe, 4'b0000);
    @(posedge clock_clk); #1;
    check("midreset_nodone", {h1.done, h0.done, h1.busy}, 3'b000);
    @(negedge clock_clk); reset_low = 1'b1;
    m_p = 0; m_pos = 32'd0; m_moved = 1'b0;
    exp1_q.delete(); exp0_q.delete();
    mon_en = 1'b1;

    run_cmd(0, 1, 0, 4, 0);       // no hold torque before any move
    run_cmd(1, 0, 2, 3, 0);       // single reverse half step to p=7
    run_cmd(2, 1, 1, 2, 0);
    mon_en = 1'b0;
    check("final_pos", h1.position, m_pos);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end
endmodule
